// File: rtl/sim_control_ext.sv
// OCP simulation-control slave: termination FSM with delay, exit code, status,
// hang watchdog, coherent 64-bit cycle counter and scratch mailboxes.
module sim_control_ext #(
  parameter int ADDR_WIDTH  = 32,
  parameter int NSCRATCH    = 4,
  parameter int DELAY_WIDTH = 32,
  parameter int WDOG_CYCLES = 0,
  parameter int FINISH_EN   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_MAddr,
  input  logic [2:0]            i_MCmd,
  input  logic [31:0]           i_MData,
  input  logic [3:0]            i_MByteEn,
  output logic                  o_SCmdAccept,
  output logic [31:0]           o_SData,
  output logic [1:0]            o_SResp,
  output logic                  o_finish,
  output logic                  o_error,
  output logic [7:0]            o_exit_code
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [2:0]  CMD_WRITE = 3'd1;
  localparam logic [2:0]  CMD_READ  = 3'd2;
  localparam logic [1:0]  RESP_NULL = 2'd0;
  localparam logic [1:0]  RESP_DVA  = 2'd1;
  localparam logic [1:0]  RESP_ERR  = 2'd3;
  localparam logic [5:0]  W_CTRL    = 6'd0;
  localparam logic [5:0]  W_DELAY   = 6'd1;
  localparam logic [5:0]  W_STATUS  = 6'd2;
  localparam logic [5:0]  W_WDOG    = 6'd3;
  localparam logic [5:0]  W_CYCLO   = 6'd4;
  localparam logic [5:0]  W_CYCHI   = 6'd5;
  localparam logic [5:0]  W_SCR0    = 6'd8;
  localparam logic [31:0] WDOG_RELOAD = 32'(WDOG_CYCLES);
  localparam bit          WDOG_EN     = (WDOG_CYCLES != 0);

  state_t                 state_q, state_d;
  logic [DELAY_WIDTH-1:0] delay_q, delay_d;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [7:0]             code_q, code_d;
  logic                   expired_q, expired_d;
  logic [31:0]            wdog_q, wdog_d;
  logic [63:0]            cyc_q, cyc_d;
  logic [31:0]            cychi_q, cychi_d;
  logic [31:0]            scratch_q [NSCRATCH];
  logic [31:0]            scratch_d [NSCRATCH];
  logic [31:0]            sdata_q, sdata_d;
  logic [1:0]             sresp_q, sresp_d;

  logic [5:0]  word;
  logic        is_wr, is_rd, term_req, wdog_wr;
  logic [31:0] delay_ext, delay_merged;
  logic        unused_addr_bits;

  assign word             = i_MAddr[7:2];
  assign unused_addr_bits = ^{i_MAddr[ADDR_WIDTH-1:8], i_MAddr[1:0]};
  assign is_wr            = (i_MCmd == CMD_WRITE);
  assign is_rd            = (i_MCmd == CMD_READ);
  assign wdog_wr          = is_wr && (word == W_WDOG);
  assign term_req         = is_wr && (word == W_CTRL) && i_MByteEn[0] && i_MData[0]
                            && (state_q == ST_IDLE);

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    delay_ext = '0;
    delay_ext[DELAY_WIDTH-1:0] = delay_q;
  end

  assign delay_merged = lane_merge(delay_ext, i_MData, i_MByteEn);

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    code_d    = code_q;
    expired_d = expired_q;
    wdog_d    = wdog_q;
    cyc_d     = cyc_q + 64'd1;
    cychi_d   = cychi_q;
    scratch_d = scratch_q;
    sdata_d   = '0;
    sresp_d   = RESP_NULL;

    case (state_q)
      ST_IDLE: begin
        if (term_req) begin
          err_d   = i_MByteEn[3] ? i_MData[31] : 1'b0;
          code_d  = i_MByteEn[1] ? i_MData[15:8] : 8'h00;
          cnt_d   = delay_q;
          state_d = ST_COUNT;
        end else if (WDOG_EN && !wdog_wr) begin
          // A reload or a termination write in the expiry cycle pre-empts expiry.
          if (wdog_q == 32'd0) begin
            err_d     = 1'b1;
            code_d    = 8'hFF;
            expired_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            wdog_d = wdog_q - 32'd1;
          end
        end
      end
      ST_COUNT: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: ;
    endcase

    if (wdog_wr) wdog_d = WDOG_RELOAD;

    if (is_wr && word == W_DELAY) delay_d = delay_merged[DELAY_WIDTH-1:0];

    if (is_rd) begin
      sresp_d = RESP_DVA;
      case (word)
        W_CTRL:   sdata_d = {err_q, 15'd0, code_q, 8'd0};
        W_DELAY:  sdata_d = delay_ext;
        W_STATUS: sdata_d = {28'd0, expired_q, err_q, state_q};
        W_WDOG:   sdata_d = wdog_q;
        W_CYCLO: begin
          sdata_d = cyc_q[31:0];
          cychi_d = cyc_q[63:32];
        end
        W_CYCHI:  sdata_d = cychi_q;
        default:  sresp_d = RESP_ERR;
      endcase
    end

    for (int i = 0; i < NSCRATCH; i++) begin
      if (word == W_SCR0 + 6'(i)) begin
        if (is_wr) scratch_d[i] = lane_merge(scratch_q[i], i_MData, i_MByteEn);
        if (is_rd) begin
          sdata_d = scratch_q[i];
          sresp_d = RESP_DVA;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      delay_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      code_q    <= 8'h00;
      expired_q <= 1'b0;
      wdog_q    <= WDOG_RELOAD;
      cyc_q     <= '0;
      cychi_q   <= '0;
      for (int i = 0; i < NSCRATCH; i++) scratch_q[i] <= '0;
      sdata_q   <= '0;
      sresp_q   <= RESP_NULL;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      code_q    <= code_d;
      expired_q <= expired_d;
      wdog_q    <= wdog_d;
      cyc_q     <= cyc_d;
      cychi_q   <= cychi_d;
      scratch_q <= scratch_d;
      sdata_q   <= sdata_d;
      sresp_q   <= sresp_d;
    end
  end

  assign o_SCmdAccept = 1'b1;
  assign o_SData      = sdata_q;
  assign o_SResp      = sresp_q;
  assign o_finish     = (state_q == ST_DONE);
  assign o_error      = o_finish & err_q;
  assign o_exit_code  = o_finish ? code_q : 8'h00;

  // Simulation-only end of run, taken on the first edge spent in DONE.
  if (FINISH_EN != 0) begin : g_finish
    always @(posedge clk) begin
      if (state_q == ST_DONE) $finish;
    end
  end

endmodule

// File: doc/sim_control_ext.md
# sim_control_ext

Parametrised OCP slave for simulation control, succeeding the single control/delay-register device. It adds an exit code, a status register, a watchdog that ends hung simulations with an error, a coherent 64-bit cycle counter and a configurable bank of scratch mailbox registers. It sits on the testbench or SoC OCP fabric as a peripheral and drives end-of-simulation.

## Interface
- ADDR_WIDTH, 32, OCP address width; only bits [7:0] are decoded.
- NSCRATCH, 4, number of scratch registers (1..24).
- DELAY_WIDTH, 32, width of the delay counter (≤32).
- WDOG_CYCLES, 0, watchdog reload value; 0 disables the watchdog.
- FINISH_EN, 1, non-synthesisable `$finish` on entering DONE when 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- i_MAddr  in  ADDR_WIDTH  OCP address
- i_MCmd  in  3  OCP command: IDLE=0, WRITE=1, READ=2
- i_MData  in  32  write data
- i_MByteEn  in  4  byte enables
- o_SCmdAccept  out  1  command accept
- o_SData  out  32  read data
- o_SResp  out  2  response: NULL=0, DVA=1, ERR=3
- o_finish  out  1  termination reached (level)
- o_error  out  1  termination with error
- o_exit_code  out  8  exit code

## Operation
Register map (byte offsets). Writes honour byte lanes.
- 0x00 CTRL (W/R)
  - bit0=1 requests termination.
  - bit31 is the error flag.
  - bits[15:8] are the exit code.
  - Reads return the latched {error, exit code} in the same bit positions.
- 0x04 DELAY (W/R): termination delay in cycles, DELAY_WIDTH bits, zero-extended on read.
- 0x08 STATUS (RO)
  - bits[1:0] = FSM state.
  - bit2 = error.
  - bit3 = watchdog expired.
- 0x0C WDOG
  - Any write reloads the watchdog to WDOG_CYCLES (data is ignored).
  - Reads return the remaining count.
- 0x10 CYCLO (RO): low word of the 64-bit free-running cycle counter. Reading it snapshots the high word.
- 0x14 CYCHI (RO): the snapshotted high word.
- 0x20+4·i SCRATCH[i], i<NSCRATCH (W/R).
- Any other address:
  - Read returns ERR with SData=0.
  - Write is ignored.

FSM: IDLE=0, COUNT=1, DONE=2.
- IDLE, on a CTRL write with byte lane 0 enabled and bit0=1:
  - Latch error = bit31 if lane 3 is enabled, else 0.
  - Latch exit code = bits[15:8] if lane 1 is enabled, else 0.
  - Load the delay counter from DELAY and go to COUNT.
- COUNT: the counter decrements each cycle; leave for DONE when it is 0.
- DONE: terminal until reset.
  - o_finish=1.
  - o_error and o_exit_code show the latched values.
- CTRL termination writes in COUNT or DONE are ignored.

Watchdog (WDOG_CYCLES≠0):
- Decrements in IDLE only, saturating at 0; frozen in COUNT and DONE.
- On reaching 0 in IDLE, go to DONE with error=1, exit code 0xFF and the expired bit set.

Simultaneous events:
- A CTRL termination write in the same cycle as watchdog expiry: the write wins and the expired bit stays 0.
- A WDOG write in the same cycle as expiry: the reload wins.

The cycle counter increments every cycle and wraps at 2^64. DELAY, SCRATCH and WDOG remain writable in every state.

## Timing
- o_SCmdAccept: tied to 1; every command is accepted in the cycle it is presented.
- Reads: o_SResp and o_SData are registered and valid exactly one cycle after the READ cycle, for one cycle. Then SResp=NULL and SData=0.
- Writes: no response (SResp stays NULL); register updated at the end of the WRITE cycle.
- Termination latency: o_finish rises DELAY+1 cycles after the clock edge that samples the CTRL write; DELAY=0 gives 1 cycle.
- Watchdog: with no WDOG writes, o_finish rises WDOG_CYCLES+1 cycles after reset deassertion or after the last WDOG write.
- Reset values:
  - All registers, counters and the CYCHI snapshot are 0.
  - State is IDLE and the watchdog is loaded with WDOG_CYCLES.
  - o_SData=0, o_SResp=NULL, o_finish=0, o_error=0, o_exit_code=0.
- Reset asserted mid-COUNT or in DONE returns the block to IDLE immediately (asynchronously).

## Test plan
- Write DELAY=8, then CTRL=0x0000_2A01 → o_finish rises 9 cycles after the write edge, o_error=0, o_exit_code=0x2A; a CTRL read returns 0x0000_2A00.
- Write CTRL=0x8000_0001 with DELAY=0 → o_finish and o_error high 1 cycle after the write; STATUS reads 0x6.
- WDOG_CYCLES=20:
  - WDOG written every 10 cycles → no finish.
  - Writes stop → finish 21 cycles later with exit code 0xFF and STATUS=0xE.
  - A CTRL write landing on the expiry cycle → STATUS bit3=0.
- SCRATCH[0..NSCRATCH-1] written with distinct patterns using MByteEn=4'b0101 → reads show only lanes 0 and 2 updated.
- Read 0x1C → SResp=ERR, SData=0 one cycle later.
- Cycle counter preloaded near 0xFFFF_FFFF via a test force:
  - CYCLO read then CYCHI read → CYCHI matches the value at the CYCLO read.
- Assert rst during COUNT → state IDLE and o_finish=0; a subsequent termination request behaves normally.
